array_element_streamer: RTL and testbench

//   Read-side counterpart to the array-assign entities: snapshots a 2-D signed array
//   (NROWS x NCOLS elements of WIDTH bits) on START.

---
 rtl/array_element_streamer.sv | 96 +++++++++
 tb/tb_array_element_streamer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/array_element_streamer.sv
// Snapshots a 2-D signed array on start and streams its elements out row-major
// over a valid/ready handshake, tagging each beat with its row, column and last flag.
module array_element_streamer #(
    parameter int NROWS = 2,
    parameter int NCOLS = 2,
    parameter int WIDTH = 16,
    localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1,
    localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a [NROWS][NCOLS],
    output logic                    busy,
    output logic signed [WIDTH-1:0] xout,
    output logic                    xvalid,
    input  logic                    xready,
    output logic [RW-1:0]           row,
    output logic [CW-1:0]           col,
    output logic                    xlast
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    localparam logic [RW-1:0] LAST_ROW = RW'(NROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);
    localparam logic          SINGLE   = (NROWS * NCOLS == 1);

    logic [0:0]              state;
    logic signed [WIDTH-1:0] snap [NROWS][NCOLS];
    logic [RW-1:0]           next_row;
    logic [CW-1:0]           next_col;
    logic                    next_last;

    // Row-major successor of the current index; only used when the current beat is not last.
    always_comb begin
        next_row = row;
        next_col = col + 1'b1;
        if (col == LAST_COL) begin
            next_col = '0;
            next_row = row + 1'b1;
        end
        next_last = (next_row == LAST_ROW) && (next_col == LAST_COL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            xvalid <= 1'b0;
            xout   <= '0;
            row    <= '0;
            col    <= '0;
            xlast  <= 1'b0;
            for (int r = 0; r < NROWS; r++) begin
                for (int c = 0; c < NCOLS; c++) begin
                    snap[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // The first element comes straight from a since snap loads on this same edge.
                        snap   <= a;
                        state  <= STREAM;
                        busy   <= 1'b1;
                        xvalid <= 1'b1;
                        xout   <= a[0][0];
                        row    <= '0;
                        col    <= '0;
                        xlast  <= SINGLE;
                    end
                end
                STREAM: begin
                    if (xvalid && xready) begin
                        if (xlast) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            xvalid <= 1'b0;
                            xlast  <= 1'b0;
                        end else begin
                            row   <= next_row;
                            col   <= next_col;
                            xout  <= snap[next_row][next_col];
                            xlast <= next_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_array_element_streamer.sv
// Directed self-checking bench for array_element_streamer at its default 2x2x16 size.
module tb_array_element_streamer;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               xready;
    logic signed [15:0] a [2][2];
    logic               busy;
    logic signed [15:0] xout;
    logic               xvalid;
    logic [0:0]         row;
    logic [0:0]         col;
    logic               xlast;

    int total = 0;
    int bad   = 0;
    int beats;

    array_element_streamer #(.NROWS(2), .NCOLS(2), .WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .busy   (busy),
        .xout   (xout),
        .xvalid (xvalid),
        .xready (xready),
        .row    (row),
        .col    (col),
        .xlast  (xlast)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] v00, input logic [15:0] v01,
                                 input logic [15:0] v10, input logic [15:0] v11,
                                 input logic s, input logic r);
        a[0][0] = v00;
        a[0][1] = v01;
        a[1][0] = v10;
        a[1][1] = v11;
        start   = s;
        xready  = r;
    endtask

    task automatic expectBeat(input string tag, input logic [15:0] x,
                              input logic r, input logic c, input logic l);
        checkOutput({tag, ".xout"},   {16'h0, xout}, {16'h0, x});
        checkOutput({tag, ".row"},    {31'h0, row},  {31'h0, r});
        checkOutput({tag, ".col"},    {31'h0, col},  {31'h0, c});
        checkOutput({tag, ".xlast"},  {31'h0, xlast}, {31'h0, l});
        checkOutput({tag, ".xvalid"}, {31'h0, xvalid}, 32'h1);
        checkOutput({tag, ".busy"},   {31'h0, busy}, 32'h1);
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, ".xvalid"}, {31'h0, xvalid}, 32'h0);
        checkOutput({tag, ".busy"},   {31'h0, busy},   32'h0);
        checkOutput({tag, ".xlast"},  {31'h0, xlast},  32'h0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick;
        tick;
        expectIdle("rst0");
        checkOutput("rst0.xout", {16'h0, xout}, 32'h0);
        checkOutput("rst0.row",  {31'h0, row},  32'h0);
        checkOutput("rst0.col",  {31'h0, col},  32'h0);
        rst = 1'b0;
        tick;

        // Basic stream
        applyStimulus(16'h0001, 16'h0002, 16'hFFFD, 16'h7FFF, 1'b1, 1'b1);
        tick;
        start = 1'b0;
        expectBeat("basic1", 16'h0001, 1'b0, 1'b0, 1'b0);
        tick;
        expectBeat("basic2", 16'h0002, 1'b0, 1'b1, 1'b0);
        tick;
        expectBeat("basic3", 16'hFFFD, 1'b1, 1'b0, 1'b0);
        tick;
        expectBeat("basic4", 16'h7FFF, 1'b1, 1'b1, 1'b1);
        tick;
        expectIdle("basic.end");
        checkOutput("basic.end.xout", {16'h0, xout}, 32'h7FFF);
        checkOutput("basic.end.row",  {31'h0, row},  32'h1);
        checkOutput("basic.end.col",  {31'h0, col},  32'h1);
        tick;

        // Backpressure on beat 2
        applyStimulus(16'h0001, 16'h0002, 16'hFFFD, 16'h7FFF, 1'b1, 1'b1);
        tick;
        start = 1'b0;
        expectBeat("bp1", 16'h0001, 1'b0, 1'b0, 1'b0);
        tick;
        xready = 1'b0;
        expectBeat("bp2", 16'h0002, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            expectBeat($sformatf("bp.hold%0d", i), 16'h0002, 1'b0, 1'b1, 1'b0);
        end
        xready = 1'b1;
        tick;
        expectBeat("bp3", 16'hFFFD, 1'b1, 1'b0, 1'b0);
        tick;
        expectBeat("bp4", 16'h7FFF, 1'b1, 1'b1, 1'b1);
        tick;
        expectIdle("bp.end");
        tick;

        // Snapshot isolation
        applyStimulus(16'h0011, 16'h0022, 16'h0033, 16'h1234, 1'b1, 1'b1);
        tick;
        start   = 1'b0;
        a[1][1] = 16'h5555;
        a[0][1] = 16'h6666;
        expectBeat("snap1", 16'h0011, 1'b0, 1'b0, 1'b0);
        tick;
        expectBeat("snap2", 16'h0022, 1'b0, 1'b1, 1'b0);
        tick;
        expectBeat("snap3", 16'h0033, 1'b1, 1'b0, 1'b0);
        tick;
        expectBeat("snap4", 16'h1234, 1'b1, 1'b1, 1'b1);
        tick;
        expectIdle("snap.end");
        tick;

        // START ignored while busy, accepted the cycle after busy falls
        applyStimulus(16'h0001, 16'h0002, 16'hFFFD, 16'h7FFF, 1'b1, 1'b1);
        tick;
        start = 1'b0;
        expectBeat("ign1", 16'h0001, 1'b0, 1'b0, 1'b0);
        tick;
        applyStimulus(16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD, 1'b1, 1'b1);
        expectBeat("ign2", 16'h0002, 1'b0, 1'b1, 1'b0);
        tick;
        start = 1'b0;
        expectBeat("ign3", 16'hFFFD, 1'b1, 1'b0, 1'b0);
        tick;
        start = 1'b1;
        expectBeat("ign4", 16'h7FFF, 1'b1, 1'b1, 1'b1);
        tick;
        expectIdle("ign.end");
        start = 1'b1;
        tick;
        start = 1'b0;
        expectBeat("new1", 16'h0AAA, 1'b0, 1'b0, 1'b0);
        tick;
        expectBeat("new2", 16'h0BBB, 1'b0, 1'b1, 1'b0);
        tick;
        tick;
        expectBeat("new4", 16'h0DDD, 1'b1, 1'b1, 1'b1);
        tick;
        expectIdle("new.end");
        tick;

        // Reset mid-stream after two accepted beats
        applyStimulus(16'h0001, 16'h0002, 16'hFFFD, 16'h7FFF, 1'b1, 1'b1);
        tick;
        start = 1'b0;
        tick;
        tick;
        expectBeat("prerst", 16'hFFFD, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expectIdle("midrst");
        checkOutput("midrst.xout", {16'h0, xout}, 32'h0);
        checkOutput("midrst.row",  {31'h0, row},  32'h0);
        checkOutput("midrst.col",  {31'h0, col},  32'h0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            expectIdle($sformatf("postrst%0d", i));
        end

        // Extremes with xready toggling every cycle
        applyStimulus(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b0);
        tick;
        start = 1'b0;
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            xready = i[0];
            #1;
            if (xvalid && xready) begin
                beats++;
                checkOutput($sformatf("ext.xout%0d", beats), {16'h0, xout}, 32'h8000);
                checkOutput($sformatf("ext.xlast%0d", beats), {31'h0, xlast},
                            {31'h0, (beats == 4)});
            end
            tick;
            if (!busy) break;
        end
        checkOutput("ext.beats", beats, 32'd4);
        expectIdle("ext.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
